serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-in, serial-out transmitter.
- Takes a WIDTH-bit word on a load strobe and shifts it out on a single line as a framed stream: idle-high, start bit 0, data LSB first, stop bit 1.
- Produces the serial bit stream that our flip-flop/shift-register capture blocks sample. It is the driving end of that single-bit data path.

Parameters:
- WIDTH, 8, data bits per frame; legal range 1..32.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx; legal range 1..1023.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset; sampled on the rising edge of clock.
- data_in  input  WIDTH  parallel word; sampled only on the edge that accepts load.
- load  input  1  request to send data_in; level-sampled.
- tx  output  1  serial line, registered.
- busy  output  1  high while a frame is in progress, registered.
- done  output  1  one-cycle pulse marking frame completion, registered.

Behaviour:
- Reset: clear=1 at a rising edge forces tx=1, busy=0, done=0, state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - Clear has priority over every other input on the same edge, including load.
  - Clear asserted mid-frame aborts the frame. tx returns to 1 on that edge. No done pulse is issued.
- States: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE:
  - tx=1, busy=0.
  - Edge with load=1: capture data_in into the shift register, go to START, set busy=1 and tx=0 on that same edge.
- Every non-IDLE state holds tx constant for exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- START: after CLKS_PER_BIT cycles go to DATA. tx = shift register bit 0.
- DATA:
  - At each bit boundary, shift the register right by 1 and increment the bit counter.
  - After WIDTH bits go to STOP (or PARITY), with tx=1 (or the parity bit).
- STOP: after CLKS_PER_BIT cycles go to IDLE. On that edge: busy=0, done=1, tx stays 1.
- done is high for exactly one cycle, the first IDLE cycle. It clears on the next edge.
- Frame length: tx is non-idle-driven for (WIDTH+2)*CLKS_PER_BIT cycles, counted from the accepting edge. The done pulse appears on the edge (WIDTH+2)*CLKS_PER_BIT after the accepting edge.
- load while busy=1 is ignored; data_in changes during a frame have no effect.
- load=1 during the done cycle is accepted on the following edge. The minimum inter-frame gap is therefore one idle cycle at tx=1.
- load held high continuously: frames repeat back-to-back, each separated by one idle cycle.
- CLKS_PER_BIT=1: one bit per cycle, same state sequence.
- Counter widths: bit counter ceil(log2(WIDTH+1)); cycle counter 10 bits. No overflow is possible within the legal ranges.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - tx carries the even-parity bit (XOR of the captured word, computed at load) for CLKS_PER_BIT cycles.
  - Frame length becomes (WIDTH+3)*CLKS_PER_BIT.
  - done timing shifts by CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic; frame as described above.

Test Plan:
- Reset: clear=1 for 2 edges with load=1 and data_in=8'hFF. Required: tx=1, busy=0, done=0 throughout; no frame starts.
- Single frame, WIDTH=8, CLKS_PER_BIT=4: data_in=8'hA5, load for 1 cycle. Required:
  - tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - busy=1 for 40 cycles.
  - done pulses once on the 40th edge after the accepting edge.
- Load ignored while busy: send 8'h3C, then pulse load with 8'hFF at cycle 10. Required: the frame carries 3C only; no second frame.
- Back-to-back: load held high with data_in=8'h01. Required: successive frames separated by exactly one tx=1 idle cycle; a done pulse per frame.
- Mid-frame clear: assert clear at cycle 17 of a 8'h55 frame. Required: tx=1, busy=0 on that edge; no done pulse; a next load starts a clean frame.
- Parity, SERIAL_FRAME_TX_PARITY_EN defined, data_in=8'h07. Required:
  - parity bit=1 in bit slot 9.
  - Frame is 44 cycles; done on the 44th edge.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed parallel-in serial-out transmitter (idle-high, start 0, LSB first, stop 1).
// Optional even-parity slot before the stop bit when SERIAL_FRAME_TX_PARITY_EN is defined.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [9:0]    CYC_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t           r_state;
  logic [9:0]       r_cyc;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             r_par;
`endif

  logic             w_bit_end;
  logic [WIDTH-1:0] w_shift_nx;

  assign w_bit_end  = (r_cyc == CYC_LAST);
  assign w_shift_nx = r_shift >> 1;

  assign tx   = r_tx;
  assign busy = r_busy;
  assign done = r_done;

  // Frame sequencer: every non-idle state holds tx for CLKS_PER_BIT cycles.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (load) begin
            r_shift <= data_in;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_par   <= ^data_in;
`endif
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
            r_cyc   <= '0;
            r_bit   <= '0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cyc <= r_cyc + 10'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_shift <= w_shift_nx;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == BIT_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_tx <= w_shift_nx[0];
            end
          end else begin
            r_cyc <= r_cyc + 10'd1;
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 10'd1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_tx    <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 10'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
          r_cyc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed, table-driven bench for serial_frame_tx.
// Expected frames are hand-written {stop, data, start} words plus a hand parity bit.
module tb_serial_frame_tx;

  localparam int CPB = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic       clock = 1'b0;
  logic       clear;
  logic       load;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;

  vec_t vecs [7];

  serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clock   (clock),
    .clear   (clear),
    .data_in (data_in),
    .load    (load),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic slot_bit(input logic [9:0] fr, input logic par, input int s);
    if (s < 9) return fr[s];
    if (NSLOT == 11 && s == 9) return par;
    return 1'b1;
  endfunction

  // Entered just after a negedge; returns just after a negedge.
  task automatic send_frame(input logic [7:0] d, input logic [9:0] fr,
                            input logic par, input bit hold, input int ign);
    load    = 1'b1;
    data_in = d;
    @(negedge clock);
    if (!hold) load = 1'b0;
    data_in = ~d;
    for (int k = 0; k < NSLOT * CPB; k++) begin
      chk("tx", tx, slot_bit(fr, par, k / CPB));
      chk("busy", busy, 1'b1);
      chk("done_low", done, 1'b0);
      if (k == ign) begin
        load    = 1'b1;
        data_in = 8'hFF;
      end else if (!hold) begin
        load = 1'b0;
      end
      @(negedge clock);
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("tx_end", tx, 1'b1);
    if (!hold) begin
      @(negedge clock);
      chk("done_clr", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("tx_idle", tx, 1'b1);
    end
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_tx", tx, 1'b1);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h3C, 10'h278, 1'b0};
    vecs[2] = '{8'h00, 10'h200, 1'b0};
    vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[4] = '{8'h01, 10'h202, 1'b1};
    vecs[5] = '{8'h55, 10'h2AA, 1'b0};
    vecs[6] = '{8'h07, 10'h20E, 1'b1};

    // Reset dominates a simultaneous load.
    clear   = 1'b1;
    load    = 1'b1;
    data_in = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
    end
    clear = 1'b0;
    load  = 1'b0;
    idle_check(2);

    // Table of single frames.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].frame, vecs[i].par, 1'b0, -1);
      idle_check(1);
    end

    // Load pulsed mid-frame is ignored.
    send_frame(8'h3C, 10'h278, 1'b0, 1'b0, 10);
    idle_check(NSLOT * CPB + 4);

    // Load held high: frames back-to-back with one idle cycle.
    send_frame(8'h01, 10'h202, 1'b1, 1'b1, -1);
    send_frame(8'h01, 10'h202, 1'b1, 1'b1, -1);
    send_frame(8'h01, 10'h202, 1'b1, 1'b0, -1);
    idle_check(3);

    // Clear at cycle 17 aborts the frame without a done pulse.
    load    = 1'b1;
    data_in = 8'h55;
    @(negedge clock);
    load = 1'b0;
    for (int k = 0; k < 17; k++) begin
      chk("mc_tx", tx, slot_bit(10'h2AA, 1'b0, k / CPB));
      chk("mc_busy", busy, 1'b1);
      @(negedge clock);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("mc_clr_tx", tx, 1'b1);
    chk("mc_clr_busy", busy, 1'b0);
    chk("mc_clr_done", done, 1'b0);
    idle_check(NSLOT * CPB);
    send_frame(8'h55, 10'h2AA, 1'b0, 1'b0, -1);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
